game_ctrl_fsm: RTL and testbench

Parametrised second-generation minesweeper game controller. It sequences mine placement, move load, decode, ALU evaluation and display. It adds several things the first controller lacked: a working display phase, win detection by counting revealed cells, move bounds checking, wait-state timeouts with a sticky error state, and restarting a new game from any terminal state. It sits between the user-input front end and the datapath (RNG placer, decoder, ALU, display driver).

---
 rtl/minesweeper_pkg.sv | 37 +++
 rtl/game_ctrl_fsm_if.sv | 50 +++++
 rtl/game_ctrl_fsm_wait_timer.sv | 30 +++
 rtl/game_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper game controller: state encoding,
// default board constants and the win threshold.
package minesweeper_pkg;

  localparam int DEF_ROWS    = 8;
  localparam int DEF_COLS    = 8;
  localparam int DEF_MINES   = 10;
  localparam int DEF_WAIT_TO = 255;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_PLACE        = 4'd1,
    S_PLACE_WAIT   = 4'd2,
    S_READY        = 4'd3,
    S_LOAD         = 4'd4,
    S_DECODE       = 4'd5,
    S_DECODE_WAIT  = 4'd6,
    S_ALU          = 4'd7,
    S_ALU_WAIT     = 4'd8,
    S_DISPLAY      = 4'd9,
    S_DISPLAY_WAIT = 4'd10,
    S_WIN          = 4'd11,
    S_LOSE         = 4'd12,
    S_ERROR        = 4'd13
  } state_e;

  // Number of safe cells; revealing this many wins the game.
  function automatic int win_threshold(input int rows, input int cols, input int mines);
    return rows * cols - mines;
  endfunction

  function automatic logic is_wait(input state_e s);
    return (s == S_PLACE_WAIT) || (s == S_DECODE_WAIT) ||
           (s == S_ALU_WAIT)   || (s == S_DISPLAY_WAIT);
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_if.sv
// Bundle between the game controller, the user front end and the datapath.
// slave is the controller's view, master the view of whoever drives it.
interface game_ctrl_fsm_if
  import minesweeper_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  localparam int ADDR_W = $clog2(ROWS * COLS);
  localparam int CNT_W  = $clog2(ROWS * COLS + 1);

  logic              place;
  logic              place_done;
  logic              data_in;
  logic [ADDR_W-1:0] data;
  logic              decode_done;
  logic              alu_done;
  logic              gameover;
  logic [CNT_W-1:0]  reveal_cnt;
  logic              disp_done;

  logic [3:0]        state;
  logic              start;
  logic              load;
  logic              decode;
  logic              alu;
  logic              display;
  logic [ADDR_W-1:0] move_addr;
  logic [CNT_W-1:0]  moves;
  logic [CNT_W-1:0]  revealed;
  logic              win;
  logic              lose;
  logic              timeout_err;
  logic              bad_move;

  modport slave (
    input  place, place_done, data_in, data, decode_done, alu_done,
           gameover, reveal_cnt, disp_done,
    output state, start, load, decode, alu, display, move_addr, moves,
           revealed, win, lose, timeout_err, bad_move
  );

  modport master (
    output place, place_done, data_in, data, decode_done, alu_done,
           gameover, reveal_cnt, disp_done,
    input  state, start, load, decode, alu, display, move_addr, moves,
           revealed, win, lose, timeout_err, bad_move
  );

endinterface

// File: rtl/game_ctrl_fsm_wait_timer.sv
// Cycle counter shared by all wait states; expired flags WAIT_TO cycles spent.
module wait_timer #(
  parameter int WAIT_TO = 255,
  parameter int TO_W    = $clog2(WAIT_TO + 1)
) (
  input  logic            clka,
  input  logic            restart,
  input  logic            clr,
  input  logic            en,
  output logic [TO_W-1:0] cnt,
  output logic            expired
);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(WAIT_TO);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt     = cnt_q;
  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/game_ctrl_fsm.sv
// Minesweeper game sequencer: placement, move load/decode/ALU/display, win/lose
// detection, move bounds checking and wait-state timeouts.
module game_ctrl_fsm
  import minesweeper_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int MINES   = DEF_MINES,
  parameter int WAIT_TO = DEF_WAIT_TO
) (
  input  logic          clka,
  input  logic          restart,
  game_ctrl_fsm_if.slave bus
);
  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int CNT_W  = $clog2(CELLS + 1);
  localparam int TO_W   = $clog2(WAIT_TO + 1);

  localparam logic [ADDR_W:0]  CELLS_A = (ADDR_W + 1)'(CELLS);
  localparam logic [CNT_W:0]   CELLS_S = (CNT_W + 1)'(CELLS);
  localparam logic [CNT_W-1:0] CELLS_C = CNT_W'(CELLS);
  localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(win_threshold(ROWS, COLS, MINES));

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] move_addr_q, move_addr_d;
  logic [CNT_W-1:0]  moves_q, moves_d;
  logic [CNT_W-1:0]  revealed_q, revealed_d;
  logic              win_q, win_d, lose_q, lose_d, to_err_q, to_err_d;
  logic              bad_q, bad_d;
  logic              start_q, load_q, decode_q, alu_q, display_q;
  logic              tmr_clr, tmr_en, to_exp;
  logic [TO_W-1:0]   tmr_cnt_unused;
  logic              addr_ok;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > CELLS_S) ? CELLS_C : s[CNT_W-1:0];
  endfunction

  assign addr_ok = ({1'b0, bus.data} < CELLS_A);
  assign tmr_en  = is_wait(state_q);
  assign tmr_clr = is_wait(state_d) && (state_d != state_q);

  wait_timer #(.WAIT_TO(WAIT_TO), .TO_W(TO_W)) u_timer (
    .clka    (clka),
    .restart (restart),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .cnt     (tmr_cnt_unused),
    .expired (to_exp)
  );

  always_comb begin
    state_d     = state_q;
    move_addr_d = move_addr_q;
    moves_d     = moves_q;
    revealed_d  = revealed_q;
    win_d       = win_q;
    lose_d      = lose_q;
    to_err_d    = to_err_q;
    bad_d       = 1'b0;
    case (state_q)
      S_IDLE:       if (bus.place) state_d = S_PLACE;
      S_PLACE:      state_d = S_PLACE_WAIT;
      S_PLACE_WAIT: begin
        if (bus.place_done) state_d = S_READY;
        else if (to_exp)    state_d = S_ERROR;
      end
      S_READY: begin
        if (bus.data_in) begin
          if (addr_ok) begin
            state_d     = S_LOAD;
            move_addr_d = bus.data;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_LOAD:        state_d = S_DECODE;
      S_DECODE:      state_d = S_DECODE_WAIT;
      S_DECODE_WAIT: begin
        if (bus.decode_done) state_d = S_ALU;
        else if (to_exp)     state_d = S_ERROR;
      end
      S_ALU:         state_d = S_ALU_WAIT;
      S_ALU_WAIT: begin
        if (bus.alu_done) begin
          moves_d    = sat_add(moves_q, CNT_W'(1));
          revealed_d = sat_add(revealed_q, bus.reveal_cnt);
          // A mine hit loses even when the same move reaches the win threshold.
          if (bus.gameover)              state_d = S_LOSE;
          else if (revealed_d >= WIN_C)  state_d = S_WIN;
          else                           state_d = S_DISPLAY;
        end else if (to_exp) begin
          state_d = S_ERROR;
        end
      end
      S_DISPLAY:      state_d = S_DISPLAY_WAIT;
      S_DISPLAY_WAIT: begin
        if (bus.disp_done) state_d = S_READY;
        else if (to_exp)   state_d = S_ERROR;
      end
      S_WIN, S_LOSE, S_ERROR: if (bus.place) state_d = S_PLACE;
      default:        state_d = S_IDLE;
    endcase

    if (state_d == S_PLACE) begin
      move_addr_d = '0;
      moves_d     = '0;
      revealed_d  = '0;
      win_d       = 1'b0;
      lose_d      = 1'b0;
      to_err_d    = 1'b0;
    end
    if (state_d == S_WIN)   win_d    = 1'b1;
    if (state_d == S_LOSE)  lose_d   = 1'b1;
    if (state_d == S_ERROR) to_err_d = 1'b1;
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q     <= S_IDLE;
      move_addr_q <= '0;
      moves_q     <= '0;
      revealed_q  <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      to_err_q    <= 1'b0;
      bad_q       <= 1'b0;
      start_q     <= 1'b0;
      load_q      <= 1'b0;
      decode_q    <= 1'b0;
      alu_q       <= 1'b0;
      display_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      move_addr_q <= move_addr_d;
      moves_q     <= moves_d;
      revealed_q  <= revealed_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      to_err_q    <= to_err_d;
      bad_q       <= bad_d;
      start_q     <= (state_d == S_PLACE);
      load_q      <= (state_d == S_LOAD);
      decode_q    <= (state_d == S_DECODE);
      alu_q       <= (state_d == S_ALU);
      display_q   <= (state_d == S_DISPLAY);
    end
  end

  assign bus.state       = state_q;
  assign bus.start       = start_q;
  assign bus.load        = load_q;
  assign bus.decode      = decode_q;
  assign bus.alu         = alu_q;
  assign bus.display     = display_q;
  assign bus.move_addr   = move_addr_q;
  assign bus.moves       = moves_q;
  assign bus.revealed    = revealed_q;
  assign bus.win         = win_q;
  assign bus.lose        = lose_q;
  assign bus.timeout_err = to_err_q;
  assign bus.bad_move    = bad_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm: directed scenarios plus randomized
// games scored against a move-level reference model.
module tb_game_ctrl_fsm;

  localparam int N   = 64;
  localparam int TH  = 54;
  localparam int WTO = 255;

  logic clka;
  logic restart;
  int   checks = 0;
  int   errors = 0;
  int   m_moves;
  int   m_rev;

  game_ctrl_fsm_if #(.ROWS(8), .COLS(8)) bus1();
  game_ctrl_fsm_if #(.ROWS(5), .COLS(5)) bus2();

  game_ctrl_fsm #(.ROWS(8), .COLS(8), .MINES(10), .WAIT_TO(WTO)) dut (
    .clka(clka), .restart(restart), .bus(bus1)
  );

  game_ctrl_fsm #(.ROWS(5), .COLS(5), .MINES(4), .WAIT_TO(WTO)) dut_small (
    .clka(clka), .restart(restart), .bus(bus2)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic noise();
    bus1.place      = 1'($urandom_range(0, 1));
    bus1.data_in    = 1'($urandom_range(0, 1));
    bus1.data       = 6'($urandom);
    bus1.gameover   = 1'($urandom_range(0, 1));
    bus1.reveal_cnt = 7'($urandom);
  endtask

  task automatic quiet();
    bus1.place    = 1'b0;
    bus1.data_in  = 1'b0;
    bus1.gameover = 1'b0;
  endtask

  task automatic test_reset();
    restart = 1'b1;
    bus1.place = 0; bus1.place_done = 0; bus1.data_in = 0; bus1.data = 0;
    bus1.decode_done = 0; bus1.alu_done = 0; bus1.gameover = 0;
    bus1.reveal_cnt = 0; bus1.disp_done = 0;
    bus2.place = 0; bus2.place_done = 0; bus2.data_in = 0; bus2.data = 0;
    bus2.decode_done = 0; bus2.alu_done = 0; bus2.gameover = 0;
    bus2.reveal_cnt = 0; bus2.disp_done = 0;
    m_moves = 0; m_rev = 0;
    repeat (2) tick();
    #2 restart = 1'b0;
    tick();
    checks++;
    if (bus1.state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", bus1.state);
    end
    checks++;
    if ({bus1.start, bus1.load, bus1.decode, bus1.alu, bus1.display, bus1.move_addr,
         bus1.moves, bus1.revealed, bus1.win, bus1.lose, bus1.timeout_err,
         bus1.bad_move} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs want all 0");
    end
  endtask

  task automatic new_game();
    bus1.place = 1'b1;
    tick();
    bus1.place = 1'b0;
    m_moves = 0; m_rev = 0;
    checks++;
    if ({bus1.state, bus1.start} !== {4'd1, 1'b1}) begin
      errors++; $display("FAIL place_start: state=%0d start=%0b want 1/1", bus1.state, bus1.start);
    end
    checks++;
    if ({bus1.moves, bus1.revealed, bus1.win, bus1.lose, bus1.timeout_err,
         bus1.move_addr} !== '0) begin
      errors++; $display("FAIL place_clear: moves=%0d revealed=%0d win=%0b lose=%0b to=%0b addr=%0d want all 0",
                         bus1.moves, bus1.revealed, bus1.win, bus1.lose, bus1.timeout_err, bus1.move_addr);
    end
    tick();
    checks++;
    if ({bus1.state, bus1.start} !== {4'd2, 1'b0}) begin
      errors++; $display("FAIL place_wait: state=%0d start=%0b want 2/0", bus1.state, bus1.start);
    end
    bus1.place_done = 1'b1;
    tick();
    bus1.place_done = 1'b0;
    checks++;
    if (bus1.state !== 4'd3) begin
      errors++; $display("FAIL ready: state=%0d want 3", bus1.state);
    end
  endtask

  task automatic enter_decode_wait(input logic [5:0] addr);
    bus1.data_in = 1'b1;
    bus1.data    = addr;
    tick();
    bus1.data_in = 1'b0;
    checks++;
    if ({bus1.state, bus1.load, bus1.decode, bus1.move_addr} !== {4'd4, 1'b1, 1'b0, addr}) begin
      errors++; $display("FAIL load: state=%0d load=%0b decode=%0b addr=%0d want 4/1/0/%0d",
                         bus1.state, bus1.load, bus1.decode, bus1.move_addr, addr);
    end
    tick();
    checks++;
    if ({bus1.state, bus1.load, bus1.decode} !== {4'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL decode: state=%0d load=%0b decode=%0b want 5/0/1",
                         bus1.state, bus1.load, bus1.decode);
    end
    tick();
    checks++;
    if ({bus1.state, bus1.decode, bus1.alu} !== {4'd6, 1'b0, 1'b0}) begin
      errors++; $display("FAIL decode_wait: state=%0d decode=%0b alu=%0b want 6/0/0",
                         bus1.state, bus1.decode, bus1.alu);
    end
  endtask

  task automatic do_move(input logic [5:0] addr, input logic [6:0] rc, input logic go,
                         input int dd, input int ad, input int pd, output int st);
    enter_decode_wait(addr);
    repeat (dd) begin noise(); tick(); end
    quiet();
    bus1.decode_done = 1'b1;
    tick();
    bus1.decode_done = 1'b0;
    checks++;
    if ({bus1.state, bus1.alu} !== {4'd7, 1'b1}) begin
      errors++; $display("FAIL alu: state=%0d alu=%0b want 7/1", bus1.state, bus1.alu);
    end
    tick();
    checks++;
    if ({bus1.state, bus1.alu} !== {4'd8, 1'b0}) begin
      errors++; $display("FAIL alu_wait: state=%0d alu=%0b want 8/0", bus1.state, bus1.alu);
    end
    repeat (ad) begin noise(); tick(); end
    quiet();
    bus1.alu_done   = 1'b1;
    bus1.gameover   = go;
    bus1.reveal_cnt = rc;
    tick();
    bus1.alu_done   = 1'b0;
    bus1.gameover   = 1'b0;
    m_moves = (m_moves + 1 > N) ? N : m_moves + 1;
    m_rev   = (m_rev + int'(rc) > N) ? N : m_rev + int'(rc);
    st = go ? 12 : ((m_rev >= TH) ? 11 : 9);
    checks++;
    if ({bus1.state, bus1.moves, bus1.revealed, bus1.win, bus1.lose, bus1.display} !==
        {4'(st), 7'(m_moves), 7'(m_rev), st == 11, st == 12, st == 9}) begin
      errors++; $display("FAIL alu_result: state=%0d moves=%0d rev=%0d win=%0b lose=%0b disp=%0b want %0d/%0d/%0d/%0b/%0b/%0b",
                         bus1.state, bus1.moves, bus1.revealed, bus1.win, bus1.lose, bus1.display,
                         st, m_moves, m_rev, st == 11, st == 12, st == 9);
    end
    if (st == 9) begin
      tick();
      checks++;
      if ({bus1.state, bus1.display} !== {4'd10, 1'b0}) begin
        errors++; $display("FAIL display_wait: state=%0d disp=%0b want 10/0", bus1.state, bus1.display);
      end
      repeat (pd) begin noise(); tick(); end
      quiet();
      bus1.disp_done = 1'b1;
      tick();
      bus1.disp_done = 1'b0;
      checks++;
      if (bus1.state !== 4'd3) begin
        errors++; $display("FAIL display_done: state=%0d want 3", bus1.state);
      end
    end
  endtask

  task automatic test_first_move();
    int st;
    new_game();
    do_move(6'd63, 7'd5, 1'b0, 2, 3, 1, st);
  endtask

  task automatic test_ignore();
    bus1.place = 1'b1;
    tick();
    bus1.place = 1'b0;
    checks++;
    if ({bus1.state, bus1.start} !== {4'd3, 1'b0}) begin
      errors++; $display("FAIL place_in_ready: state=%0d start=%0b want 3/0", bus1.state, bus1.start);
    end
  endtask

  task automatic test_lose_priority();
    int st;
    do_move(6'd10, 7'd49, 1'b1, 0, 0, 0, st);
    checks++;
    if ({bus1.win, bus1.lose} !== 2'b01) begin
      errors++; $display("FAIL lose_priority: win=%0b lose=%0b want 0/1", bus1.win, bus1.lose);
    end
  endtask

  task automatic test_win();
    int st;
    new_game();
    do_move(6'd1, 7'd30, 1'b0, 1, 1, 1, st);
    do_move(6'd2, 7'd24, 1'b0, 1, 1, 1, st);
    bus1.data_in = 1'b1;
    bus1.data    = 6'd5;
    repeat (3) tick();
    bus1.data_in = 1'b0;
    checks++;
    if ({bus1.state, bus1.win, bus1.load, bus1.revealed} !== {4'd11, 1'b1, 1'b0, 7'd54}) begin
      errors++; $display("FAIL win_hold: state=%0d win=%0b load=%0b rev=%0d want 11/1/0/54",
                         bus1.state, bus1.win, bus1.load, bus1.revealed);
    end
  endtask

  task automatic test_bad_move();
    logic [4:0] a;
    bus2.place = 1'b1; tick(); bus2.place = 1'b0;
    tick();
    bus2.place_done = 1'b1; tick(); bus2.place_done = 1'b0;
    checks++;
    if (bus2.state !== 4'd3) begin
      errors++; $display("FAIL small_ready: state=%0d want 3", bus2.state);
    end
    a = 5'($urandom_range(25, 31));
    bus2.data_in = 1'b1;
    bus2.data    = a;
    tick();
    bus2.data_in = 1'b0;
    checks++;
    if ({bus2.state, bus2.bad_move, bus2.load, bus2.moves} !== {4'd3, 1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL bad_move: state=%0d bad=%0b load=%0b moves=%0d want 3/1/0/0",
                         bus2.state, bus2.bad_move, bus2.load, bus2.moves);
    end
    tick();
    checks++;
    if ({bus2.state, bus2.bad_move} !== {4'd3, 1'b0}) begin
      errors++; $display("FAIL bad_move_pulse: state=%0d bad=%0b want 3/0", bus2.state, bus2.bad_move);
    end
    bus2.data_in = 1'b1;
    bus2.data    = 5'd24;
    tick();
    bus2.data_in = 1'b0;
    checks++;
    if ({bus2.state, bus2.bad_move, bus2.move_addr} !== {4'd4, 1'b0, 5'd24}) begin
      errors++; $display("FAIL last_cell: state=%0d bad=%0b addr=%0d want 4/0/24",
                         bus2.state, bus2.bad_move, bus2.move_addr);
    end
  endtask

  task automatic test_timeout();
    new_game();
    enter_decode_wait(6'd7);
    repeat (WTO) tick();
    checks++;
    if ({bus1.state, bus1.timeout_err} !== {4'd6, 1'b0}) begin
      errors++; $display("FAIL timeout_early: state=%0d to=%0b want 6/0", bus1.state, bus1.timeout_err);
    end
    tick();
    checks++;
    if ({bus1.state, bus1.timeout_err} !== {4'd13, 1'b1}) begin
      errors++; $display("FAIL timeout_err: state=%0d to=%0b want 13/1", bus1.state, bus1.timeout_err);
    end
    tick();
    checks++;
    if (bus1.state !== 4'd13) begin
      errors++; $display("FAIL error_hold: state=%0d want 13", bus1.state);
    end
    new_game();
    enter_decode_wait(6'd8);
    repeat (WTO) tick();
    bus1.decode_done = 1'b1;
    tick();
    bus1.decode_done = 1'b0;
    checks++;
    if ({bus1.state, bus1.alu, bus1.timeout_err} !== {4'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL done_at_limit: state=%0d alu=%0b to=%0b want 7/1/0",
                         bus1.state, bus1.alu, bus1.timeout_err);
    end
  endtask

  task automatic test_restart();
    repeat (3) tick();
    checks++;
    if (bus1.state !== 4'd8) begin
      errors++; $display("FAIL pre_restart: state=%0d want 8", bus1.state);
    end
    #3 restart = 1'b1;
    #1;
    checks++;
    if ({bus1.state, bus1.start, bus1.load, bus1.decode, bus1.alu, bus1.display,
         bus1.move_addr, bus1.moves, bus1.revealed, bus1.win, bus1.lose,
         bus1.timeout_err, bus1.bad_move} !== '0) begin
      errors++; $display("FAIL async_restart: state=%0d moves=%0d addr=%0d want all 0",
                         bus1.state, bus1.moves, bus1.move_addr);
    end
    #1 restart = 1'b0;
    m_moves = 0; m_rev = 0;
    tick();
    checks++;
    if (bus1.state !== 4'd0) begin
      errors++; $display("FAIL after_restart: state=%0d want 0", bus1.state);
    end
  endtask

  task automatic test_random_games();
    int st;
    logic [6:0] rc;
    for (int g = 0; g < 6; g++) begin
      new_game();
      st = 9;
      for (int mv = 0; mv < 40 && st == 9; mv++) begin
        rc = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(60, 127)) : 7'($urandom_range(0, 12));
        do_move(6'($urandom_range(0, 63)), rc, ($urandom_range(0, 15) == 0),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), st);
      end
      checks++;
      if (st == 9) begin
        errors++; $display("FAIL game_end: game %0d no terminal state after 40 moves want win/lose", g);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_ignore();
    test_lose_priority();
    test_win();
    test_bad_move();
    test_timeout();
    test_restart();
    test_random_games();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached want completion");
    $fatal(1, "watchdog");
  end

endmodule
